dmem_responder: RTL and testbench

- Multi-cycle data-memory responder: the target end of the load/store request interface driven by the M stage.
- Replaces the zero-latency RAM with a valid/ready request channel and a one-cycle response pulse.
- Handles byte, half and word loads and stores, with sign- or zero-extension on loads.
- Flags misaligned and illegal accesses instead of performing them.
- The pipeline stalls from req_ready low until rsp_valid.

---
 rtl/dmem_responder_pkg.sv | 28 ++
 rtl/dmem_responder_if.sv | 24 ++
 rtl/dmem_lane_align.sv | 58 +++++
 rtl/dmem_responder.sv | 190 +++++++++++++++++++
 tb/tb_dmem_responder.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: funct3 codes, FSM states,
// latency bounds and a saturating counter helper.
package dmem_responder_pkg;

    localparam logic [2:0] F_LB  = 3'b000;
    localparam logic [2:0] F_LH  = 3'b001;
    localparam logic [2:0] F_LW  = 3'b010;
    localparam logic [2:0] F_LBU = 3'b100;
    localparam logic [2:0] F_LHU = 3'b101;
    localparam logic [2:0] F_SB  = 3'b000;
    localparam logic [2:0] F_SH  = 3'b001;
    localparam logic [2:0] F_SW  = 3'b010;

    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 15;
    localparam int CNT_W   = $clog2(LAT_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store request channel between the M stage (master) and the responder (slave).
interface dmem_responder_if #(
    parameter int ADDR_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [2:0]        req_funct;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_funct, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_funct, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: byte enables, shifted store data,
// extended load data and the misalign/illegal-access flag.
module dmem_lane_align
    import dmem_responder_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  funct,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext,
    output logic        err
);

    logic [4:0]  shamt_s;
    logic [31:0] rsh_s;
    logic [31:0] ext_s;
    logic [3:0]  be_raw_s;
    logic        bad_s;

    // Decode access size, alignment and extension from funct3.
    always_comb begin
        shamt_s    = {addr_lo, 3'b000};
        rsh_s      = rword >> shamt_s;
        wdata_lane = wdata << shamt_s;
        be_raw_s   = 4'b0000;
        ext_s      = 32'h0000_0000;
        bad_s      = 1'b0;
        case (funct)
            F_LB, F_LBU: begin
                be_raw_s = 4'b0001 << addr_lo;
                ext_s    = funct[2] ? {24'h00_0000, rsh_s[7:0]}
                                    : {{24{rsh_s[7]}}, rsh_s[7:0]};
            end
            F_LH, F_LHU: begin
                bad_s    = addr_lo[0];
                be_raw_s = addr_lo[1] ? 4'b1100 : 4'b0011;
                ext_s    = funct[2] ? {16'h0000, rsh_s[15:0]}
                                    : {{16{rsh_s[15]}}, rsh_s[15:0]};
            end
            F_LW: begin
                bad_s    = (addr_lo != 2'b00);
                be_raw_s = 4'b1111;
                ext_s    = rword;
            end
            default: begin
                bad_s = 1'b1;
            end
        endcase
        // Stores have no zero/sign-extended variants.
        err       = bad_s | (we & funct[2]);
        be        = err ? 4'b0000 : be_raw_s;
        rdata_ext = (err | we) ? 32'h0000_0000 : ext_s;
    end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder with valid/ready requests and a one-cycle response.
// Optional DMEM_STATS_EN adds saturating read/write/error response counters.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic             n_rst,
    dmem_responder_if.slave  bus
`ifdef DMEM_STATS_EN
    ,
    output logic [15:0]      rd_cnt,
    output logic [15:0]      wr_cnt,
    output logic [15:0]      err_cnt
`endif
);

    localparam int IDX_W = ADDR_W - 2;
    localparam int DEPTH = 1 << IDX_W;
    localparam bit DIRECT = (LATENCY <= LAT_MIN);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : CNT_ZERO;

    state_t            state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              ready_r;
    logic              valid_r;
    logic [31:0]       rdata_r;
    logic              err_r;

    logic              cap_we_r;
    logic [ADDR_W-1:0] cap_addr_r;
    logic [2:0]        cap_funct_r;
    logic [31:0]       cap_wdata_r;

    logic              resp_we_r;
    logic [IDX_W-1:0]  resp_idx_r;
    logic [3:0]        resp_be_r;
    logic [31:0]       resp_wsh_r;

    logic [31:0]       mem_r [DEPTH];

    logic              accept_s;
    logic              commit_s;
    logic              to_resp_s;
    logic              nxt_we_s;
    logic [ADDR_W-1:0] nxt_addr_s;
    logic [2:0]        nxt_funct_s;
    logic [31:0]       nxt_wdata_s;
    logic [IDX_W-1:0]  rd_idx_s;
    logic [31:0]       wr_word_s;
    logic [31:0]       rd_word_s;
    logic [3:0]        be_s;
    logic [31:0]       wsh_s;
    logic [31:0]       ext_s;
    logic              err_s;

    assign bus.req_ready = ready_r;
    assign bus.rsp_valid = valid_r;
    assign bus.rsp_rdata = rdata_r;
    assign bus.rsp_err   = err_r;

    // Select the request about to enter RESP and forward a store committing on the same edge.
    always_comb begin
        accept_s  = bus.req_valid & ready_r;
        commit_s  = valid_r & resp_we_r & ~err_r;
        to_resp_s = (accept_s & DIRECT) | ((state_r == S_WAIT) & (cnt_r == CNT_ZERO));
        if (accept_s) begin
            nxt_we_s    = bus.req_we;
            nxt_addr_s  = bus.req_addr;
            nxt_funct_s = bus.req_funct;
            nxt_wdata_s = bus.req_wdata;
        end else begin
            nxt_we_s    = cap_we_r;
            nxt_addr_s  = cap_addr_r;
            nxt_funct_s = cap_funct_r;
            nxt_wdata_s = cap_wdata_r;
        end
        wr_word_s = mem_r[resp_idx_r];
        for (int i = 0; i < 4; i++) begin
            wr_word_s[8*i +: 8] = resp_be_r[i] ? resp_wsh_r[8*i +: 8] : mem_r[resp_idx_r][8*i +: 8];
        end
        rd_idx_s  = nxt_addr_s[ADDR_W-1:2];
        rd_word_s = (commit_s && (rd_idx_s == resp_idx_r)) ? wr_word_s : mem_r[rd_idx_s];
    end

    dmem_lane_align u_align (
        .we         (nxt_we_s),
        .funct      (nxt_funct_s),
        .addr_lo    (nxt_addr_s[1:0]),
        .wdata      (nxt_wdata_s),
        .rword      (rd_word_s),
        .be         (be_s),
        .wdata_lane (wsh_s),
        .rdata_ext  (ext_s),
        .err        (err_s)
    );

    // Request FSM, latency counter, request capture and registered response.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r     <= S_IDLE;
            cnt_r       <= CNT_ZERO;
            ready_r     <= 1'b1;
            valid_r     <= 1'b0;
            rdata_r     <= 32'h0000_0000;
            err_r       <= 1'b0;
            cap_we_r    <= 1'b0;
            cap_addr_r  <= {ADDR_W{1'b0}};
            cap_funct_r <= 3'b000;
            cap_wdata_r <= 32'h0000_0000;
            resp_we_r   <= 1'b0;
            resp_idx_r  <= {IDX_W{1'b0}};
            resp_be_r   <= 4'b0000;
            resp_wsh_r  <= 32'h0000_0000;
        end else begin
            valid_r <= to_resp_s;
            if (accept_s) begin
                cap_we_r    <= bus.req_we;
                cap_addr_r  <= bus.req_addr;
                cap_funct_r <= bus.req_funct;
                cap_wdata_r <= bus.req_wdata;
            end
            if (to_resp_s) begin
                rdata_r    <= ext_s;
                err_r      <= err_s;
                resp_we_r  <= nxt_we_s;
                resp_idx_r <= rd_idx_s;
                resp_be_r  <= be_s;
                resp_wsh_r <= wsh_s;
            end
            case (state_r)
                S_IDLE, S_RESP: begin
                    if (accept_s && DIRECT) begin
                        state_r <= S_RESP;
                        ready_r <= 1'b1;
                    end else if (accept_s) begin
                        state_r <= S_WAIT;
                        cnt_r   <= CNT_LOAD;
                        ready_r <= 1'b0;
                    end else begin
                        state_r <= S_IDLE;
                        ready_r <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (cnt_r == CNT_ZERO) begin
                        state_r <= S_RESP;
                        ready_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end

    // Storage write; the store lands on the edge that ends its RESP cycle.
    always_ff @(posedge clk) begin
        if (commit_s) begin
            mem_r[resp_idx_r] <= wr_word_s;
        end
    end

`ifdef DMEM_STATS_EN
    // Saturating per-kind response counters.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rd_cnt  <= 16'h0000;
            wr_cnt  <= 16'h0000;
            err_cnt <= 16'h0000;
        end else if (valid_r) begin
            if (err_r) begin
                err_cnt <= sat_inc16(err_cnt);
            end else if (resp_we_r) begin
                wr_cnt <= sat_inc16(wr_cnt);
            end else begin
                rd_cnt <= sat_inc16(rd_cnt);
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: byte-level memory model checked on every response,
// plus directed literal vectors, throughput, mid-transaction reset and LATENCY=1 cases.
module tb_dmem_responder;

    localparam int AW  = 16;
    localparam int LAT = 2;

    logic clk   = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    dmem_responder_if #(.ADDR_W(AW)) bus ();
    dmem_responder_if #(.ADDR_W(AW)) bus1 ();

`ifdef DMEM_STATS_EN
    logic [15:0] rd_cnt, wr_cnt, err_cnt, rd_cnt1, wr_cnt1, err_cnt1;
`endif

    dmem_responder #(.ADDR_W(AW), .LATENCY(LAT)) u_dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
`ifdef DMEM_STATS_EN
        , .rd_cnt(rd_cnt), .wr_cnt(wr_cnt), .err_cnt(err_cnt)
`endif
    );

    dmem_responder #(.ADDR_W(AW), .LATENCY(1)) u_dut1 (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus1)
`ifdef DMEM_STATS_EN
        , .rd_cnt(rd_cnt1), .wr_cnt(wr_cnt1), .err_cnt(err_cnt1)
`endif
    );

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [2:0]  funct;
        logic [31:0] wdata;
        int          due;
        bit          has_lit;
        logic [31:0] lit_rdata;
        logic        lit_err;
    } req_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    req_t exp_q[$];
    int   acc_log[$];
    logic [7:0] mbytes [0:65535];
    int   m_rd = 0, m_wr = 0, m_err = 0;
    bit          lit_en = 1'b0;
    logic [31:0] lit_rdata = 32'h0;
    logic        lit_err = 1'b0;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: apply one access to the byte array in program order.
    task automatic model_apply(input req_t r, output logic [31:0] rd, output logic er);
        int n;
        logic [31:0] v;
        logic [31:0] ones;
        case (r.funct)
            3'b000, 3'b100: n = 1;
            3'b001, 3'b101: n = 2;
            3'b010:         n = 4;
            default:        n = 0;
        endcase
        if (n == 0) er = 1'b1;
        else        er = ((int'(r.addr) % n) != 0) || (r.we && r.funct[2]);
        rd = 32'h0;
        if (er) begin
            m_err++;
        end else if (r.we) begin
            m_wr++;
            for (int i = 0; i < n; i++) mbytes[int'(r.addr) + i] = r.wdata[8*i +: 8];
        end else begin
            m_rd++;
            v = 32'h0;
            for (int i = 0; i < n; i++) v = v | (32'(mbytes[int'(r.addr) + i]) << (8*i));
            ones = 32'hFFFF_FFFF;
            if (!r.funct[2] && n < 4 && v[8*n-1]) v = v | (ones << (8*n));
            rd = v;
        end
    endtask

    always @(posedge clk) begin : monitor
        req_t r;
        if (n_rst && bus.req_valid && bus.req_ready) begin
            r.we = bus.req_we; r.addr = bus.req_addr; r.funct = bus.req_funct;
            r.wdata = bus.req_wdata; r.due = cyc + LAT;
            r.has_lit = lit_en; r.lit_rdata = lit_rdata; r.lit_err = lit_err;
            exp_q.push_back(r);
            acc_log.push_back(cyc);
        end
        cyc = cyc + 1;
    end

    always @(negedge clk) begin : compare
        req_t r;
        logic [31:0] mr;
        logic me;
        if (n_rst) begin
            if (bus.rsp_valid) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL spurious_rsp: got rsp_valid 1 expected 0 (cycle %0d)", cyc);
                end else begin
                    r = exp_q.pop_front();
                    model_apply(r, mr, me);
                    chk32("rsp_cycle", cyc, r.due);
                    chk32("rsp_rdata", bus.rsp_rdata, mr);
                    chk32("rsp_err", {31'b0, bus.rsp_err}, {31'b0, me});
                    if (r.has_lit) begin
                        chk32("lit_rdata", bus.rsp_rdata, r.lit_rdata);
                        chk32("lit_err", {31'b0, bus.rsp_err}, {31'b0, r.lit_err});
                    end
                end
            end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
                checks++; errors++;
                $display("FAIL missing_rsp: got rsp_valid 0 expected 1 (cycle %0d)", cyc);
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic issue(input logic we, input logic [15:0] addr, input logic [2:0] f,
                         input logic [31:0] wd, input bit hl, input logic [31:0] lr, input logic le);
        int waited = 0;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = addr;
        bus.req_funct = f; bus.req_wdata = wd;
        lit_en = hl; lit_rdata = lr; lit_err = le;
        while (!bus.req_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.req_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout: got req_ready 0 expected 1 (cycle %0d)", cyc);
            bus.req_valid = 1'b0;
        end else begin
            @(posedge clk);
        end
    endtask

    task automatic ld(input logic [15:0] a, input logic [2:0] f, input logic [31:0] e);
        issue(1'b0, a, f, 32'h0, 1'b1, e, 1'b0);
    endtask

    task automatic st(input logic [15:0] a, input logic [2:0] f, input logic [31:0] d);
        issue(1'b1, a, f, d, 1'b1, 32'h0, 1'b0);
    endtask

    task automatic bad(input logic we, input logic [15:0] a, input logic [2:0] f, input logic [31:0] d);
        issue(we, a, f, d, 1'b1, 32'h0, 1'b1);
    endtask

    task automatic idle_drain();
        int w = 0;
        @(negedge clk);
        bus.req_valid = 1'b0;
        lit_en = 1'b0;
        while (exp_q.size() != 0 && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mbytes[i] = 8'h00;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = 16'h0;
        bus.req_funct = 3'b000; bus.req_wdata = 32'h0;
        bus1.req_valid = 1'b0; bus1.req_we = 1'b0; bus1.req_addr = 16'h0;
        bus1.req_funct = 3'b000; bus1.req_wdata = 32'h0;
        repeat (3) @(negedge clk);
        chk32("rst_ready", {31'b0, bus.req_ready}, 32'h1);
        chk32("rst_valid", {31'b0, bus.rsp_valid}, 32'h0);
        chk32("rst_rdata", bus.rsp_rdata, 32'h0);
        chk32("rst_err", {31'b0, bus.rsp_err}, 32'h0);
        n_rst = 1'b1;

        st(16'h0010, 3'b010, 32'hDEADBEEF);
        ld(16'h0010, 3'b010, 32'hDEADBEEF);
        ld(16'h0011, 3'b000, 32'hFFFFFFBE);
        ld(16'h0011, 3'b100, 32'h000000BE);
        ld(16'h0012, 3'b001, 32'hFFFFDEAD);
        ld(16'h0012, 3'b101, 32'h0000DEAD);
        st(16'h0013, 3'b000, 32'h00000012);
        st(16'h0010, 3'b001, 32'h00005678);
        ld(16'h0010, 3'b010, 32'h12AD5678);
        bad(1'b0, 16'h0012, 3'b010, 32'h0);
        bad(1'b1, 16'h0011, 3'b001, 32'h0000FFFF);
        ld(16'h0010, 3'b010, 32'h12AD5678);
        bad(1'b0, 16'h0010, 3'b011, 32'h0);
        bad(1'b1, 16'h0010, 3'b100, 32'h000000FF);
        st(16'hFFFC, 3'b010, 32'hCAFEF00D);
        ld(16'hFFFE, 3'b001, 32'hFFFFCAFE);
        ld(16'hFFFC, 3'b101, 32'h0000F00D);
        idle_drain();

        acc_log.delete();
        ld(16'h0010, 3'b010, 32'h12AD5678);
        ld(16'h0012, 3'b100, 32'h000000AD);
        ld(16'h0010, 3'b101, 32'h00005678);
        idle_drain();
        chk32("accept_count", acc_log.size(), 32'd3);
        if (acc_log.size() == 3) begin
            chk32("accept_gap0", acc_log[1] - acc_log[0], 32'd2);
            chk32("accept_gap1", acc_log[2] - acc_log[1], 32'd2);
        end

        st(16'h0020, 3'b010, 32'hAAAAAAAA);
        @(negedge clk);
        n_rst = 1'b0;
        exp_q.delete();
        bus.req_valid = 1'b0;
        m_rd = 0; m_wr = 0; m_err = 0;
        #1;
        chk32("midrst_valid", {31'b0, bus.rsp_valid}, 32'h0);
        chk32("midrst_ready", {31'b0, bus.req_ready}, 32'h1);
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        repeat (3) @(negedge clk);
`ifdef DMEM_STATS_EN
        chk32("rst_rd_cnt", {16'h0, rd_cnt}, 32'h0);
        chk32("rst_wr_cnt", {16'h0, wr_cnt}, 32'h0);
        chk32("rst_err_cnt", {16'h0, err_cnt}, 32'h0);
`endif
        ld(16'h0020, 3'b010, 32'h00000000);
        ld(16'h0010, 3'b010, 32'h12AD5678);
        bad(1'b0, 16'h0011, 3'b001, 32'h0);
        idle_drain();
`ifdef DMEM_STATS_EN
        chk32("stat_rd", {16'h0, rd_cnt}, 32'(m_rd));
        chk32("stat_wr", {16'h0, wr_cnt}, 32'(m_wr));
        chk32("stat_err", {16'h0, err_cnt}, 32'(m_err));
`endif

        // LATENCY=1 instance: one accept and one response per cycle, with store forwarding.
        @(negedge clk);
        bus1.req_valid = 1'b1; bus1.req_we = 1'b1; bus1.req_addr = 16'h0040;
        bus1.req_funct = 3'b010; bus1.req_wdata = 32'h11223344;
        chk32("l1_ready0", {31'b0, bus1.req_ready}, 32'h1);
        @(negedge clk);
        chk32("l1_valid1", {31'b0, bus1.rsp_valid}, 32'h1);
        chk32("l1_ready1", {31'b0, bus1.req_ready}, 32'h1);
        chk32("l1_st_rdata", bus1.rsp_rdata, 32'h0);
        bus1.req_we = 1'b0; bus1.req_addr = 16'h0040; bus1.req_funct = 3'b010;
        @(negedge clk);
        chk32("l1_valid2", {31'b0, bus1.rsp_valid}, 32'h1);
        chk32("l1_ready2", {31'b0, bus1.req_ready}, 32'h1);
        chk32("l1_lw_rdata", bus1.rsp_rdata, 32'h11223344);
        bus1.req_addr = 16'h0041; bus1.req_funct = 3'b100;
        @(negedge clk);
        chk32("l1_valid3", {31'b0, bus1.rsp_valid}, 32'h1);
        chk32("l1_lbu_rdata", bus1.rsp_rdata, 32'h00000033);
        chk32("l1_lbu_err", {31'b0, bus1.rsp_err}, 32'h0);
        bus1.req_valid = 1'b0;
        @(negedge clk);
        chk32("l1_valid_off", {31'b0, bus1.rsp_valid}, 32'h0);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
